fifo_write_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single write port of the async FIFO among NUM_REQ producers
//   in the write clock domain. Grants burst ownership to one requester at a time and throttles on
//   the FIFO full / almost-full flags from the write-side flag generators. Drives write_enable and

---
 rtl/fifo_write_arbiter_pkg.sv | 16 +
 rtl/fifo_write_arbiter_if.sv | 33 +++
 rtl/fifo_write_arbiter_picker.sv | 34 +++
 rtl/fifo_write_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int MAX_NUM_REQ = 8;

    // Owner index width; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-write-port signals of the arbiter, grouped as one bus.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    import fifo_arb_pkg::*;

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic                          fifo_full;
    logic                          fifo_almost_full;
    logic [NUM_REQ-1:0]            grant;
    logic                          write_enable;
    logic [DATA_WIDTH-1:0]         write_data;
    logic [IDX_W-1:0]              owner;
    logic                          burst_active;

    // master: the arbiter, which drives the FIFO write port
    modport master (
        input  req, req_data, req_last, fifo_full, fifo_almost_full,
        output grant, write_enable, write_data, owner, burst_active
    );

    // slave: the producers and FIFO flag logic around the arbiter
    modport slave (
        output req, req_data, req_last, fifo_full, fifo_almost_full,
        input  grant, write_enable, write_data, owner, burst_active
    );

endinterface

// File: rtl/fifo_write_arbiter_picker.sv
// Combinational round-robin search: first requester at last_winner+1, +2, ... (mod NUM_REQ).
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_winner_i,
    output logic [IDX_W-1:0]   pick_o,
    output logic               found_o
);

    logic [IDX_W-1:0] cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(last_winner_i) + gi + 1) % NUM_REQ);
        end
    endgenerate

    // Scan farthest offset first so the nearest requesting candidate is the final winner.
    always_comb begin
        pick_o  = '0;
        found_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                pick_o  = cand[k];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers,
// throttled by the FIFO full / almost-full flags.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_write_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_winner_q, last_winner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0]      pick;
    logic                  found;
    logic                  accept;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i         (bus.req),
        .last_winner_i (last_winner_q),
        .pick_o        (pick),
        .found_o       (found)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign words[gi]     = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.grant[gi] = accept && (owner_q == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            last_winner_q <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        beat_cnt_d    = beat_cnt_q;
        accept        = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // almost-full only gates the start of a new burst
                if (found && !bus.fifo_full && !bus.fifo_almost_full) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                accept = bus.req[owner_q] && !bus.fifo_full;
                if (!bus.req[owner_q]) begin
                    state_d       = ARB_IDLE;
                    last_winner_d = owner_q;
                    beat_cnt_d    = '0;
                end else if (accept) begin
                    if (bus.req_last[owner_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d       = ARB_IDLE;
                        last_winner_d = owner_q;
                        beat_cnt_d    = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.write_enable = accept;
    assign bus.write_data   = accept ? words[owner_q] : '0;
    assign bus.owner        = owner_q;
    assign bus.burst_active = (state_q == ARB_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized producers against a transaction-level reference; per-cycle and per-write
// expectations are queued by the driver and consumed by an independent monitor.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;
    localparam int NCYC = 800;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic we;
        logic busy;
        int   owner;
    } cyc_t;

    typedef struct {
        int          who;
        logic [DW-1:0] data;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   run_done = 0;

    // Reference model: burst ownership described as plain integers.
    bit m_busy   = 0;
    int m_owner  = 0;
    int m_lw     = N - 1;
    int m_beats  = 0;

    // Producer state: each requester holds one pending word until it is written.
    logic [DW-1:0] p_data [N];
    bit            p_last [N];
    bit            p_has  [N];
    bit            p_acc  [N];

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        cyc_t c;
        wr_t  w;
        bit   picked;
        int   cand;
        c.busy  = m_busy;
        c.owner = m_owner;
        c.we    = 1'b0;
        for (int i = 0; i < N; i++) p_acc[i] = 0;
        if (!rst_n) begin
            m_busy  = 0;
            m_owner = 0;
            m_lw    = N - 1;
            m_beats = 0;
            c.busy  = 1'b0;
            c.owner = 0;
        end else if (!m_busy) begin
            if (!bus.fifo_full && !bus.fifo_almost_full) begin
                picked = 0;
                for (int k = 1; k <= N; k++) begin
                    cand = (m_lw + k) % N;
                    if (!picked && bus.req[cand]) begin
                        picked  = 1;
                        m_owner = cand;
                    end
                end
                if (picked) begin
                    m_busy  = 1;
                    m_beats = 0;
                end
            end
        end else if (!bus.req[m_owner]) begin
            m_busy = 0;
            m_lw   = m_owner;
        end else if (!bus.fifo_full) begin
            c.we   = 1'b1;
            w.who  = m_owner;
            w.data = p_data[m_owner];
            wr_q.push_back(w);
            p_acc[m_owner] = 1;
            m_beats++;
            if (p_last[m_owner] || m_beats == MB) begin
                m_busy = 0;
                m_lw   = m_owner;
            end
        end
        cyc_q.push_back(c);
    endtask

    // Driver: new inputs just after each rising edge, expectations queued immediately.
    initial begin
        int last_pct, full_pct, af_pct;
        bus.req              = '0;
        bus.req_data         = '0;
        bus.req_last         = '0;
        bus.fifo_full        = 1'b0;
        bus.fifo_almost_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_data[i] = '0;
            p_last[i] = 0;
            p_has[i]  = 0;
            p_acc[i]  = 0;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            rst_n    = !(cyc < 3 || (cyc >= 200 && cyc < 202));
            last_pct = (cyc < 400) ? 50 : 5;
            full_pct = (cyc < 700) ? 10 : 30;
            af_pct   = (cyc < 600) ? 15 : 40;
            for (int i = 0; i < N; i++) begin
                if (p_acc[i]) p_has[i] = 0;
                if (!p_has[i] && $urandom_range(99) < 60) begin
                    p_has[i]  = 1;
                    p_data[i] = DW'($urandom);
                    p_last[i] = ($urandom_range(99) < last_pct);
                end
                bus.req[i]                = p_has[i] && ($urandom_range(99) >= 6);
                bus.req_last[i]           = p_last[i];
                bus.req_data[i*DW +: DW]  = p_data[i];
            end
            bus.fifo_full        = ($urandom_range(99) < full_pct);
            bus.fifo_almost_full = ($urandom_range(99) < af_pct);
            model_step();
        end
        @(negedge clk);
        #1;
        run_done = 1;
        chk("cycle_queue_drained", cyc_q.size(), 0);
        chk("write_queue_drained", wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: compares DUT outputs mid-cycle against queued expectations.
    initial begin
        cyc_t          c;
        wr_t           w;
        logic [N-1:0]  g;
        forever begin
            @(negedge clk);
            if (!run_done && cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                chk("burst_active", bus.burst_active, c.busy);
                chk("owner", bus.owner, c.owner);
                chk("write_enable", bus.write_enable, c.we);
                chk("grant_onehot0", $onehot0(bus.grant), 1);
                chk("we_eq_or_grant", bus.write_enable, |bus.grant);
                chk("no_grant_when_full", (bus.fifo_full && |bus.grant), 0);
                if (!bus.write_enable)
                    chk("write_data_idle_zero", bus.write_data, 0);
                if (bus.write_enable) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        w = wr_q.pop_front();
                        g = '0;
                        g[w.who] = 1'b1;
                        chk("write_grant", bus.grant, g);
                        chk("write_data", bus.write_data, w.data);
                        $display("WRITE t=%0t req=%0d data=0x%02h", $time, w.who, bus.write_data);
                    end
                end
            end
        end
    end

endmodule
